sprite_bank: RTL

Parametrised multi-sprite pixel store for the tank game video path. Holds NUM_SPR square sprites of SPR_DIM×SPR_DIM pixels. The HPS loads and inspects them through an Avalon-MM slave. The VGA renderer fetches pixels through a pipelined read port that applies per-request rotation (0/90/180/270°) and horizontal mirroring, so one stored tank image serves all four headings. It replaces the fixed 4096×8 per-sprite single-port RAMs.

---
 rtl/sprite_pkg.sv | 23 ++
 rtl/sprite_dpram.sv | 54 +++++
 rtl/sprite_bank.sv | 119 +++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite store and its video fetch path.
package sprite_pkg;

  // Rotation applied by the video fetch port, clockwise.
  typedef enum logic [1:0] {
    DIR_0   = 2'd0,
    DIR_90  = 2'd1,
    DIR_180 = 2'd2,
    DIR_270 = 2'd3
  } sprite_dir_t;

  // Palette index that the renderer treats as see-through.
  localparam logic [7:0] TRANSP_DEFAULT = 8'hFF;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/sprite_dpram.sv
// True dual-port sprite RAM: port A host read/write (write-first), port B
// read-only (read-first). Both outputs are registered, share one clock
// enable, and only reload when their read enable is set.
module sprite_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_we,
  input  logic              a_re,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_re,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Array write from the host port.
  // NOTE: the array sits in its own clocked block without reset so it maps
  // onto block RAM; sprite contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (clken && a_we) mem[a_addr] <= a_wdata;
  end

  // Port A output register: new data is forwarded when a write and read
  // hit together.
  // NOTE: non-blocking assignments make every register in the block sample
  // the pre-edge array contents, which is what gives port B read-first
  // behaviour against a simultaneous port A write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata <= '0;
    end else if (clken && a_re) begin
      a_rdata <= a_we ? a_wdata : mem[a_addr];
    end
  end

  // Port B output register, returns the pre-write contents on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      b_rdata <= '0;
    end else if (clken && b_re) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/sprite_bank.sv
// Multi-sprite pixel store: Avalon-MM host port plus a two-stage video fetch
// port that rotates/mirrors the requested coordinate before reading.
module sprite_bank
  import sprite_pkg::*;
#(
  parameter int                DATA_W  = 8,
  parameter int                SPR_DIM = 64,
  parameter int                NUM_SPR = 4,
  parameter logic [DATA_W-1:0] TRANSP  = DATA_W'(TRANSP_DEFAULT),
  localparam int               C       = clog2(SPR_DIM),
  localparam int               S       = (NUM_SPR > 1) ? clog2(NUM_SPR) : 1,
  localparam int               AW      = S + 2 * C
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clken,
  input  logic [AW-1:0]     address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid,
  input  logic              vid_valid,
  input  logic [S-1:0]      vid_id,
  input  logic [C-1:0]      vid_x,
  input  logic [C-1:0]      vid_y,
  input  logic [1:0]        vid_dir,
  input  logic              vid_flip,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_transp
);

  // With a single sprite the sprite-index bit carries no storage.
  localparam int               MAW   = clog2(NUM_SPR) + 2 * C;
  localparam logic [C-1:0]     MAX_C = C'(SPR_DIM - 1);

  logic              host_wr;
  logic              host_rd;
  sprite_dir_t       dir;
  logic [C-1:0]      xf;
  logic [C-1:0]      sx;
  logic [C-1:0]      sy;
  logic [AW-1:0]     fetch_addr;
  logic              s1_valid;
  logic [MAW-1:0]    s1_addr;
  logic              has_pix;

  // A write always wins over a simultaneous read and suppresses the response.
  assign host_wr = chipselect & write;
  assign host_rd = chipselect & read & ~write;
  assign dir     = sprite_dir_t'(vid_dir);

  // Mirror first, then rotate the destination coordinate back to the source.
  // NOTE: sx/sy get a value before the case so no path leaves them unassigned
  // and no latch is inferred.
  always_comb begin
    xf = vid_flip ? (MAX_C - vid_x) : vid_x;
    sx = xf;
    sy = vid_y;
    case (dir)
      DIR_0:   begin sx = xf;             sy = vid_y;          end
      DIR_90:  begin sx = vid_y;          sy = MAX_C - xf;     end
      DIR_180: begin sx = MAX_C - xf;     sy = MAX_C - vid_y;  end
      DIR_270: begin sx = MAX_C - vid_y;  sy = xf;             end
      default: ;
    endcase
  end

  assign fetch_addr = {vid_id, sy, sx};

  // Stage 1: register the transformed address and request valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
    end else if (clken) begin
      s1_valid <= vid_valid;
      s1_addr  <= fetch_addr[MAW-1:0];
    end
  end

  // Stage 2 and host response: valid pulses line up with the RAM output
  // registers; has_pix marks that pix_data holds a fetched pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_valid     <= 1'b0;
      has_pix       <= 1'b0;
      readdatavalid <= 1'b0;
    end else if (clken) begin
      pix_valid     <= s1_valid;
      has_pix       <= has_pix | s1_valid;
      readdatavalid <= host_rd;
    end
  end

  // pix_data is the RAM's own output register, so the compare follows it
  // directly and reads 0 until the first pixel arrives after reset.
  assign pix_transp = has_pix & (pix_data == TRANSP);

  sprite_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (MAW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .clken   (clken),
    .a_addr  (address[MAW-1:0]),
    .a_we    (host_wr),
    .a_re    (host_rd),
    .a_wdata (writedata),
    .a_rdata (readdata),
    .b_addr  (s1_addr),
    .b_re    (s1_valid),
    .b_rdata (pix_data)
  );

endmodule
